// File: rtl/frame_scanout_pkg.sv
// Shared constants, swap-state encoding and address helper for the frame scanout block.
package frame_scanout_pkg;

    // Framebuffer geometry: 160x120 pixels per buffer, each pixel covers 4x4 screen pixels
    localparam int unsigned FB_W      = 160;
    localparam int unsigned FB_H      = 120;
    localparam int unsigned FB_SCALE  = 4;
    localparam int unsigned FB_WORDS  = FB_W * FB_H;
    localparam int unsigned FB_ADDR_W = 16;

    // RGB444 layout {r, g, b}
    localparam int unsigned RGB_R_W = 4;
    localparam int unsigned RGB_G_W = 4;
    localparam int unsigned RGB_B_W = 4;
    localparam int unsigned RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

    typedef enum logic {
        SWAP_IDLE = 1'b0,
        SWAP_ACK  = 1'b1
    } swap_state_e;

    // Word address of the buffer pixel under screen position (h, v) in buffer sel
    function automatic logic [FB_ADDR_W-1:0] fb_pixel_addr(input logic       sel,
                                                           input logic [9:0] h,
                                                           input logic [9:0] v);
        int unsigned a;
        a = (sel ? FB_WORDS : 32'd0)
          + (32'(v) / FB_SCALE) * FB_W
          + (32'(h) / FB_SCALE);
        return a[FB_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/frame_scanout_pipe_delay.sv
// Fixed-depth shift register with asynchronous clear, used to carry timing flags
// alongside the framebuffer read.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock; clear every stage on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_scanout.sv
// Framebuffer scanout: turns timing-generator coordinates into framebuffer reads,
// realigns the returned pixel with delayed sync, and double-buffers on frame edges.
module frame_scanout
    import frame_scanout_pkg::*;
#(
    parameter int          MEM_LATENCY = 2,
    parameter logic [11:0] BORDER_RGB  = 12'h000
) (
    input  logic        pix_clk,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        active,
    input  logic        hsync,
    input  logic        vsync,
    output logic [15:0] fb_addr,
    output logic        fb_rd,
    input  logic [11:0] fb_data,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        buf_sel,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [15:0] frame_count
);

    logic [15:0] addr_p0_q;
    logic        rd_p0_q;
    logic [2:0]  flags_p1;
    logic [11:0] rgb_p2_q;
    logic        hsync_p2_q;
    logic        vsync_p2_q;

    swap_state_e state_q, state_d;
    logic        buf_sel_q, buf_sel_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        at480, at480_q, boundary;

    // Stage 0: issue the framebuffer read; address holds outside the active area
    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            addr_p0_q <= '0;
            rd_p0_q   <= 1'b0;
        end else begin
            rd_p0_q <= active;
            if (active) addr_p0_q <= fb_pixel_addr(buf_sel_q, hcount, vcount);
        end
    end

    // Stage 1: flags ride MEM_LATENCY+1 cycles so they line up with returning fb_data
    pipe_delay #(
        .WIDTH (3),
        .DEPTH (MEM_LATENCY + 1)
    ) u_flag_dly (
        .clk_i (pix_clk),
        .rst_i (reset),
        .d_i   ({active, hsync, vsync}),
        .q_o   (flags_p1)
    );

    // Stage 2: register colour (border outside active area) together with the syncs
    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            rgb_p2_q   <= '0;
            hsync_p2_q <= 1'b0;
            vsync_p2_q <= 1'b0;
        end else begin
            rgb_p2_q   <= flags_p1[2] ? fb_data : BORDER_RGB;
            hsync_p2_q <= flags_p1[1];
            vsync_p2_q <= flags_p1[0];
        end
    end

    // Frame boundary is the rising edge of vcount==480 against last cycle's compare
    assign at480    = (vcount == 10'd480);
    assign boundary = at480 && !at480_q;

    // Swap/frame state register; compare history resets high so a line already at
    // 480 when reset releases is not mistaken for a fresh frame edge
    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            state_q       <= SWAP_IDLE;
            buf_sel_q     <= 1'b0;
            frame_count_q <= '0;
            at480_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            buf_sel_q     <= buf_sel_d;
            frame_count_q <= frame_count_d;
            at480_q       <= at480;
        end
    end

    // Next-state: toggle buffer and enter ACK for one cycle on a requested boundary
    always_comb begin
        state_d       = state_q;
        buf_sel_d     = buf_sel_q;
        frame_count_d = frame_count_q;
        if (boundary) frame_count_d = frame_count_q + 16'd1;
        if (state_q == SWAP_ACK) begin
            state_d = SWAP_IDLE;
        end else if (boundary && swap_req) begin
            state_d   = SWAP_ACK;
            buf_sel_d = ~buf_sel_q;
        end
    end

    assign fb_addr     = addr_p0_q;
    assign fb_rd       = rd_p0_q;
    assign vga_r       = rgb_p2_q[RGB_B_W + RGB_G_W +: RGB_R_W];
    assign vga_g       = rgb_p2_q[RGB_B_W +: RGB_G_W];
    assign vga_b       = rgb_p2_q[0 +: RGB_B_W];
    assign vga_hsync   = hsync_p2_q;
    assign vga_vsync   = vsync_p2_q;
    assign swap_ack    = (state_q == SWAP_ACK);
    assign buf_sel     = buf_sel_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout with a transaction-level reference model and
// a latency-accurate framebuffer memory model.
`timescale 1ns/1ps
module tb_frame_scanout;

    localparam int          ML     = 2;
    localparam int          L      = ML + 2;
    localparam logic [11:0] BORDER = 12'h000;

    logic        pix_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [9:0]  hcount  = '0;
    logic [9:0]  vcount  = '0;
    logic        active  = 1'b0;
    logic        hsync   = 1'b0;
    logic        vsync   = 1'b0;
    logic [15:0] fb_addr;
    logic        fb_rd;
    logic [11:0] fb_data = 12'hFFF;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic        buf_sel;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    frame_scanout #(
        .MEM_LATENCY (ML),
        .BORDER_RGB  (BORDER)
    ) dut (
        .pix_clk     (pix_clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .active      (active),
        .hsync       (hsync),
        .vsync       (vsync),
        .fb_addr     (fb_addr),
        .fb_rd       (fb_rd),
        .fb_data     (fb_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .buf_sel     (buf_sel),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .frame_count (frame_count)
    );

    always #5 pix_clk = ~pix_clk;

    // Framebuffer contents: distinct-ish pattern, with one pinned word
    function automatic logic [11:0] mem_val(input int unsigned a);
        if (a == 32'd162) return 12'hA5C;
        return 12'((a * 32'd37 + 32'd5) ^ (a >> 4));
    endfunction

    // Screen position -> buffer word, straight from the geometry
    function automatic logic [15:0] addr_of(input logic sel, input logic [9:0] h, input logic [9:0] v);
        int unsigned a;
        a = (sel ? 32'd19200 : 32'd0) + (32'(v) / 32'd4) * 32'd160 + 32'(h) / 32'd4;
        return a[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vout_t;

    vout_t       exp_q[$];
    logic        rd_h[$];
    logic [15:0] addr_h[$];
    vout_t       cur, nxt;
    logic [15:0] m_addr, m_fc, a_now;
    logic        m_rd, m_buf, m_ack, m_prev480, bnd, r_old;
    logic [15:0] a_old;

    // Memory model, reference model and per-cycle compare, all mid-cycle
    always @(negedge pix_clk) begin
        rd_h.push_back(fb_rd);
        addr_h.push_back(fb_addr);
        if (rd_h.size() > ML) begin
            r_old   = rd_h.pop_front();
            a_old   = addr_h.pop_front();
            fb_data = r_old ? mem_val(32'(a_old)) : 12'hFFF;
        end else begin
            fb_data = 12'hFFF;
        end

        if (reset) begin
            m_addr = '0; m_rd = 1'b0; m_buf = 1'b0; m_ack = 1'b0; m_fc = '0; m_prev480 = 1'b1;
            exp_q.delete();
            for (int i = 0; i < L; i++) exp_q.push_back('0);
            cur = '0;
        end else begin
            cur = exp_q.pop_front();
        end

        check("m_fb_addr", 32'(fb_addr), 32'(m_addr));
        check("m_fb_rd", 32'(fb_rd), 32'(m_rd));
        check("m_buf_sel", 32'(buf_sel), 32'(m_buf));
        check("m_swap_ack", 32'(swap_ack), 32'(m_ack));
        check("m_frame_count", 32'(frame_count), 32'(m_fc));
        check("m_rgb", 32'({vga_r, vga_g, vga_b}), 32'(cur.rgb));
        check("m_hsync", 32'(vga_hsync), 32'(cur.hs));
        check("m_vsync", 32'(vga_vsync), 32'(cur.vs));

        if (!reset) begin
            a_now   = addr_of(m_buf, hcount, vcount);
            nxt.hs  = hsync;
            nxt.vs  = vsync;
            nxt.rgb = active ? mem_val(32'(a_now)) : BORDER;
            exp_q.push_back(nxt);
            m_rd = active;
            if (active) m_addr = a_now;
            bnd       = (vcount == 10'd480) && !m_prev480;
            m_prev480 = (vcount == 10'd480);
            m_ack     = bnd && swap_req;
            if (bnd) begin
                m_fc = m_fc + 16'd1;
                if (swap_req) m_buf = ~m_buf;
            end
        end
    end

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic drive(input int h, input int v, input logic a, input logic hs,
                         input logic vs, input logic sr);
        hcount   = 10'(h);
        vcount   = 10'(v);
        active   = a;
        hsync    = hs;
        vsync    = vs;
        swap_req = sr;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_rd", 32'(fb_rd), 32'd0);
        check("rst_buf_sel", 32'(buf_sel), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Single pixel: address, latency, colour and hsync alignment
        drive(8, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("addr_162", 32'(fb_addr), 32'd162);
        check("rd_162", 32'(fb_rd), 32'd1);
        tick(); tick();
        check("hsync_early", 32'(vga_hsync), 32'd0);
        tick();
        check("rgb_A5C", 32'({vga_r, vga_g, vga_b}), 32'hA5C);
        check("hsync_lat4", 32'(vga_hsync), 32'd1);
        tick();
        check("hsync_end", 32'(vga_hsync), 32'd0);
        check("border_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
        check("addr_hold", 32'(fb_addr), 32'd162);

        // Swap request held from line 100, honoured at the 480 edge
        drive(0, 100, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) tick();
        check("no_ack_midframe", 32'(swap_ack), 32'd0);
        check("no_swap_midframe", 32'(buf_sel), 32'd0);
        drive(0, 479, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        drive(0, 480, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("swap_ack_pulse", 32'(swap_ack), 32'd1);
        check("swap_buf_sel", 32'(buf_sel), 32'd1);
        check("swap_fc", 32'(frame_count), 32'd1);
        tick();
        check("swap_ack_once", 32'(swap_ack), 32'd0);
        repeat (4) tick();
        check("no_retoggle_480", 32'(buf_sel), 32'd1);
        check("fc_held_480", 32'(frame_count), 32'd1);
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Same pixel from the second buffer
        drive(8, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("addr_19362", 32'(fb_addr), 32'd19362);
        tick();

        // Boundary without request: count only
        drive(0, 479, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(0, 480, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("noreq_ack", 32'(swap_ack), 32'd0);
        check("noreq_buf", 32'(buf_sel), 32'd1);
        check("noreq_fc", 32'(frame_count), 32'd2);

        // Request held over two boundaries toggles twice
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
            repeat (2) tick();
            drive(0, 480, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            check("held_ack", 32'(swap_ack), 32'd1);
            check("held_buf", 32'(buf_sel), 32'(k == 0 ? 0 : 1));
        end
        check("held_fc", 32'(frame_count), 32'd4);
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Active-area sweep with gaps and sync patterns, checked by the model
        for (int r = 0; r < 4; r++) begin
            for (int h = 0; h < 640; h += 23) begin
                drive(h, r * 157 + 3, logic'((h % 7) != 3), logic'(h >= 400 && h < 460),
                      logic'(r == 2), 1'b0);
                tick();
            end
        end

        // Reset mid-frame with a pending request
        drive(40, 300, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (L + 1) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_addr", 32'(fb_addr), 32'd0);
        check("mid_rst_rd", 32'(fb_rd), 32'd0);
        check("mid_rst_buf", 32'(buf_sel), 32'd0);
        check("mid_rst_ack", 32'(swap_ack), 32'd0);
        check("mid_rst_fc", 32'(frame_count), 32'd0);
        check("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check("mid_rst_hsync", 32'(vga_hsync), 32'd0);
        check("mid_rst_vsync", 32'(vga_vsync), 32'd0);
        tick(); tick();
        reset = 1'b0;
        repeat (5) tick();
        check("post_rst_ack", 32'(swap_ack), 32'd0);
        check("post_rst_buf", 32'(buf_sel), 32'd0);
        drive(0, 480, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("post_rst_swap_ack", 32'(swap_ack), 32'd1);
        check("post_rst_swap_buf", 32'(buf_sel), 32'd1);
        check("post_rst_fc", 32'(frame_count), 32'd1);

        // Reset released while already on line 480: needs a fresh edge
        repeat (2) tick();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        repeat (4) tick();
        check("stale480_fc", 32'(frame_count), 32'd0);
        check("stale480_ack", 32'(swap_ack), 32'd0);
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(0, 480, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("fresh480_fc", 32'(frame_count), 32'd1);
        check("fresh480_ack", 32'(swap_ack), 32'd1);

        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (L + 2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
